id_decode_stage: RTL and testbench
==================================

// Module: id_decode_stage
// PURPOSE
//  Registered RV32I decode stage between IF and EX. Decodes the instruction and reads the register file.
//  Forwards operands from NFWD younger pipeline stages and stalls on load-use hazards.
//  Resolves jal/jalr/branches in ID and discards wrong-path fetches until the redirect target arrives.
//  Output is a valid/ready pipeline register feeding EX.
// PARAMETERS
//  XLEN     32  datapath / address width
//  NFWD     2   forwarding sources; index 0 = youngest (EX), highest priority
//  ALUOP_W  6   width of aluop_o encoding
//  SCNT_W   16  width of stall performance counter
// PORTS
//  clk           in   1            clock
//  rst           in   1            reset
//  in_valid_i    in   1            IF presents pc_i/inst_i
//  in_ready_o    out  1            stage accepts (or drops) the presented instruction this cycle
//  pc_i          in   XLEN         address of inst_i (not pc+4)
//  inst_i        in   32           instruction word
//  reg1_addr_o   out  5            regfile read port 1 address (rs1), combinational
//  reg2_addr_o   out  5            regfile read port 2 address (rs2), combinational
//  data1_i       in   XLEN         regfile data, port 1
//  data2_i       in   XLEN         regfile data, port 2
//  fwd_wreg_i    in   NFWD         source k writes a register
//  fwd_wd_i      in   NFWD*5       source k destination register
//  fwd_wdata_i   in   NFWD*XLEN    source k result
//  fwd_pend_i    in   NFWD         source k result not yet available (load in flight)
//  out_valid_o   out  1            EX bundle valid
//  out_ready_i   in   1            EX consumes bundle
//  aluop_o       out  ALUOP_W      operation
//  reg1_o        out  XLEN         operand 1 (forwarded rs1, or imm/pc per op)
//  reg2_o        out  XLEN         operand 2 (forwarded rs2, or imm)
//  imm_o         out  XLEN         sign-extended immediate (store offset, lui/auipc upper)
//  wd_o          out  5            destination register
//  wreg_o        out  1            write enable (forced 0 when wd_o==0)
//  link_o        out  XLEN         pc+4 for jal/jalr
//  illegal_o     out  1            bundle carries an undecodable instruction, issued as nop
//  jump_o        out  1            one-cycle redirect pulse to IF
//  jump_addr_o   out  XLEN         redirect target, valid with jump_o, held until next redirect
//  stall_cnt_o   out  SCNT_W       saturating count of load-use stall cycles
// BEHAVIOUR
//  Reset is asynchronous and active-high.
//   - All registered outputs reset to 0; state resets to RUN.
//  Forwarding: per operand, first matching k (fwd_wreg_i[k] && fwd_wd_i[k]==rs && rs!=0) wins, else regfile; rs==0 -> 0.
//  Hazard: hazard = in_valid_i && a used rs matches the winning source k with fwd_pend_i[k]=1.
//  RUN state:
//   - in_ready_o = !hazard && (!out_valid_o || out_ready_i).
//   - On accept, the bundle is registered (latency 1) and out_valid_o=1.
//   - If no new accept while out_ready_i=1, out_valid_o drops to 0.
//   - Bundle holds stable while out_valid_o && !out_ready_i.
//  Control transfer, evaluated on accept with forwarded operands:
//   - jal target is pc+immJ; jalr target is (rs1+immI)&~1; branch target is pc+immB.
//   - blt/bge compare signed; bltu/bgeu compare unsigned.
//   - Taken: next cycle jump_o=1 for exactly 1 cycle, jump_addr_o=target, state -> REDIRECT(target).
//   - jal/jalr still issue with wreg_o=1 and link_o=pc+4.
//   - Not-taken branch: no pulse, bundle issued with wreg_o=0.
//  REDIRECT state:
//   - Any valid input with pc_i != target is dropped: in_ready_o=1, no bundle, no hazard check.
//   - Input with pc_i == target is handled as in RUN and moves state to RUN.
//   - If that input is itself taken, state re-enters REDIRECT with the new target.
//  Illegal opcode/funct: aluop_o=0, wreg_o=0, illegal_o=1; never stalls, never redirects.
//  stall_cnt_o increments each cycle hazard=1 in RUN and saturates at all-ones.
//  Reset asserted mid-operation: pending jump_o and bundle are cleared; REDIRECT is abandoned.
// STRUCTURE
//  riscv_pkg: opcode/funct3/funct7 constants, aluop encodings, imm_i/s/b/u/j extract functions.
//  Sub-module id_fwd_mux (param XLEN, NFWD): operand select plus pend flag; one instance per operand.
// TESTING
//  1. addi x1,x0,-5 at pc 0x100 -> next cycle out_valid_o=1, reg1_o=0, reg2_o=0xFFFFFFFB, wd_o=1, wreg_o=1.
//  2. add x3,x1,x2; fwd0={wd=1, data=7}, fwd1={wd=2, data=9}, regfile=0 -> reg1_o=7, reg2_o=9.
//     Repeat with fwd0.wd=0 -> reg1_o from regfile.
//  3. fwd0={wd=5, pend=1}; sub x6,x5,x4 presented 2 cycles -> in_ready_o=0 both cycles, stall_cnt_o=2.
//     Then pend=0 -> accept.
//  4. beq x1,x2,+16 at 0x200, x1=x2=3 -> jump_o pulse, jump_addr_o=0x210.
//     Inputs at 0x204 and 0x208 dropped; 0x210 issued.
//  5. jalr x1,-3(x5), x5=0x1000 -> jump_addr_o=0x0FFC, link_o=pc+4; bge with -1 vs 1 -> not taken.
//  6. out_ready_i=0 for 3 cycles with bundle valid -> bundle stable, in_ready_o=0.
//     Assert rst mid-REDIRECT -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I decode constants, ALU operation encodings and immediate extractors
// shared by the ID stage and its operand forwarding muxes.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [5:0] ALU_NOP   = 6'd0;
   localparam logic [5:0] ALU_ADD   = 6'd1;
   localparam logic [5:0] ALU_SUB   = 6'd2;
   localparam logic [5:0] ALU_SLL   = 6'd3;
   localparam logic [5:0] ALU_SLT   = 6'd4;
   localparam logic [5:0] ALU_SLTU  = 6'd5;
   localparam logic [5:0] ALU_XOR   = 6'd6;
   localparam logic [5:0] ALU_SRL   = 6'd7;
   localparam logic [5:0] ALU_SRA   = 6'd8;
   localparam logic [5:0] ALU_OR    = 6'd9;
   localparam logic [5:0] ALU_AND   = 6'd10;
   localparam logic [5:0] ALU_LUI   = 6'd11;
   localparam logic [5:0] ALU_AUIPC = 6'd12;
   localparam logic [5:0] ALU_JAL   = 6'd13;
   localparam logic [5:0] ALU_JALR  = 6'd14;
   localparam logic [5:0] ALU_BEQ   = 6'd15;
   localparam logic [5:0] ALU_BNE   = 6'd16;
   localparam logic [5:0] ALU_BLT   = 6'd17;
   localparam logic [5:0] ALU_BGE   = 6'd18;
   localparam logic [5:0] ALU_BLTU  = 6'd19;
   localparam logic [5:0] ALU_BGEU  = 6'd20;
   localparam logic [5:0] ALU_LB    = 6'd21;
   localparam logic [5:0] ALU_LH    = 6'd22;
   localparam logic [5:0] ALU_LW    = 6'd23;
   localparam logic [5:0] ALU_LBU   = 6'd24;
   localparam logic [5:0] ALU_LHU   = 6'd25;
   localparam logic [5:0] ALU_SB    = 6'd26;
   localparam logic [5:0] ALU_SH    = 6'd27;
   localparam logic [5:0] ALU_SW    = 6'd28;

   function automatic logic [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source select for one register read port: youngest matching
// forwarding source wins, otherwise the register file; x0 always reads zero.
// Also reports whether the winning source is still waiting on its result.
module id_fwd_mux #(
   parameter int XLEN = 32,
   parameter int NFWD = 2
) (
   input  logic [4:0]           rs,
   input  logic [XLEN-1:0]      rf_data,
   input  logic [NFWD-1:0]      fwd_wreg,
   input  logic [NFWD*5-1:0]    fwd_wd,
   input  logic [NFWD*XLEN-1:0] fwd_wdata,
   input  logic [NFWD-1:0]      fwd_pend,
   output logic [XLEN-1:0]      data,
   output logic                 pend
);

   // Scan oldest to youngest so the lowest matching index overrides the rest
   always_comb begin
      data = rf_data;
      pend = 1'b0;
      if (rs == 5'd0) begin
         data = '0;
      end else begin
         for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && (fwd_wd[k*5 +: 5] == rs)) begin
               data = fwd_wdata[k*XLEN +: XLEN];
               pend = fwd_pend[k];
            end
         end
      end
   end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage: decodes the instruction, forwards operands, stalls on
// load-use hazards, resolves jumps/branches and drops wrong-path fetches
// until the redirect target shows up. Output is a valid/ready register.
module id_decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NFWD    = 2,
   parameter int ALUOP_W = 6,
   parameter int SCNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [XLEN-1:0]      pc_i,
   input  logic [31:0]          inst_i,
   output logic [4:0]           reg1_addr_o,
   output logic [4:0]           reg2_addr_o,
   input  logic [XLEN-1:0]      data1_i,
   input  logic [XLEN-1:0]      data2_i,
   input  logic [NFWD-1:0]      fwd_wreg_i,
   input  logic [NFWD*5-1:0]    fwd_wd_i,
   input  logic [NFWD*XLEN-1:0] fwd_wdata_i,
   input  logic [NFWD-1:0]      fwd_pend_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ALUOP_W-1:0]   aluop_o,
   output logic [XLEN-1:0]      reg1_o,
   output logic [XLEN-1:0]      reg2_o,
   output logic [XLEN-1:0]      imm_o,
   output logic [4:0]           wd_o,
   output logic                 wreg_o,
   output logic [XLEN-1:0]      link_o,
   output logic                 illegal_o,
   output logic                 jump_o,
   output logic [XLEN-1:0]      jump_addr_o,
   output logic [SCNT_W-1:0]    stall_cnt_o
);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   logic [0:0]      state;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic [XLEN-1:0] immi, imms, immb, immu, immj;
   logic [XLEN-1:0] op1, op2;
   logic            pend1, pend2;
   logic            eq, lt, ltu;
   logic            drop, hazard, accept;

   logic [5:0]      dec_aluop;
   logic [XLEN-1:0] dec_reg1, dec_reg2, dec_imm, dec_link, dec_target;
   logic [4:0]      dec_wd;
   logic            dec_wreg, dec_illegal, dec_taken, use1, use2;

   assign opcode      = inst_i[6:0];
   assign funct3      = inst_i[14:12];
   assign funct7      = inst_i[31:25];
   assign rd          = inst_i[11:7];
   assign reg1_addr_o = inst_i[19:15];
   assign reg2_addr_o = inst_i[24:20];

   assign immi = XLEN'(signed'(imm_i(inst_i)));
   assign imms = XLEN'(signed'(imm_s(inst_i)));
   assign immb = XLEN'(signed'(imm_b(inst_i)));
   assign immu = XLEN'(signed'(imm_u(inst_i)));
   assign immj = XLEN'(signed'(imm_j(inst_i)));

   id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
      .rs(reg1_addr_o), .rf_data(data1_i), .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i),
      .fwd_wdata(fwd_wdata_i), .fwd_pend(fwd_pend_i), .data(op1), .pend(pend1)
   );

   id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
      .rs(reg2_addr_o), .rf_data(data2_i), .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i),
      .fwd_wdata(fwd_wdata_i), .fwd_pend(fwd_pend_i), .data(op2), .pend(pend2)
   );

   assign eq  = (op1 == op2);
   assign lt  = ($signed(op1) < $signed(op2));
   assign ltu = (op1 < op2);

   // Instruction decode into an EX bundle plus control-transfer resolution
   always_comb begin
      dec_aluop   = ALU_NOP;
      dec_reg1    = '0;
      dec_reg2    = '0;
      dec_imm     = '0;
      dec_link    = '0;
      dec_target  = '0;
      dec_wd      = '0;
      dec_wreg    = 1'b0;
      dec_illegal = 1'b0;
      dec_taken   = 1'b0;
      use1        = 1'b0;
      use2        = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            use1 = 1'b1; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg1 = op1; dec_reg2 = immi; dec_imm = immi;
            case (funct3)
               F3_ADD:  dec_aluop = ALU_ADD;
               F3_SLT:  dec_aluop = ALU_SLT;
               F3_SLTU: dec_aluop = ALU_SLTU;
               F3_XOR:  dec_aluop = ALU_XOR;
               F3_OR:   dec_aluop = ALU_OR;
               F3_AND:  dec_aluop = ALU_AND;
               F3_SLL:  if (funct7 == F7_BASE) dec_aluop = ALU_SLL; else dec_illegal = 1'b1;
               F3_SR: begin
                  if (funct7 == F7_BASE)     dec_aluop = ALU_SRL;
                  else if (funct7 == F7_ALT) dec_aluop = ALU_SRA;
                  else                       dec_illegal = 1'b1;
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_OP: begin
            use1 = 1'b1; use2 = 1'b1; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg1 = op1; dec_reg2 = op2;
            case ({funct7, funct3})
               {F7_BASE, F3_ADD}:  dec_aluop = ALU_ADD;
               {F7_ALT,  F3_ADD}:  dec_aluop = ALU_SUB;
               {F7_BASE, F3_SLL}:  dec_aluop = ALU_SLL;
               {F7_BASE, F3_SLT}:  dec_aluop = ALU_SLT;
               {F7_BASE, F3_SLTU}: dec_aluop = ALU_SLTU;
               {F7_BASE, F3_XOR}:  dec_aluop = ALU_XOR;
               {F7_BASE, F3_SR}:   dec_aluop = ALU_SRL;
               {F7_ALT,  F3_SR}:   dec_aluop = ALU_SRA;
               {F7_BASE, F3_OR}:   dec_aluop = ALU_OR;
               {F7_BASE, F3_AND}:  dec_aluop = ALU_AND;
               default:            dec_illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_aluop = ALU_LUI; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg2 = immu; dec_imm = immu;
         end
         OPC_AUIPC: begin
            dec_aluop = ALU_AUIPC; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg1 = pc_i; dec_reg2 = immu; dec_imm = immu;
         end
         OPC_JAL: begin
            dec_aluop = ALU_JAL; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg1 = pc_i; dec_reg2 = XLEN'(4); dec_imm = immj;
            dec_link = pc_i + XLEN'(4);
            dec_taken = 1'b1; dec_target = pc_i + immj;
         end
         OPC_JALR: begin
            if (funct3 != 3'b000) begin
               dec_illegal = 1'b1;
            end else begin
               use1 = 1'b1; dec_aluop = ALU_JALR; dec_wd = rd; dec_wreg = 1'b1;
               dec_reg1 = pc_i; dec_reg2 = XLEN'(4); dec_imm = immi;
               dec_link = pc_i + XLEN'(4);
               dec_taken = 1'b1; dec_target = (op1 + immi) & ~XLEN'(1);
            end
         end
         OPC_BRANCH: begin
            use1 = 1'b1; use2 = 1'b1;
            dec_reg1 = op1; dec_reg2 = op2; dec_imm = immb;
            dec_target = pc_i + immb;
            case (funct3)
               F3_BEQ:  begin dec_aluop = ALU_BEQ;  dec_taken = eq;   end
               F3_BNE:  begin dec_aluop = ALU_BNE;  dec_taken = !eq;  end
               F3_BLT:  begin dec_aluop = ALU_BLT;  dec_taken = lt;   end
               F3_BGE:  begin dec_aluop = ALU_BGE;  dec_taken = !lt;  end
               F3_BLTU: begin dec_aluop = ALU_BLTU; dec_taken = ltu;  end
               F3_BGEU: begin dec_aluop = ALU_BGEU; dec_taken = !ltu; end
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            use1 = 1'b1; dec_wd = rd; dec_wreg = 1'b1;
            dec_reg1 = op1; dec_reg2 = immi; dec_imm = immi;
            case (funct3)
               3'b000:  dec_aluop = ALU_LB;
               3'b001:  dec_aluop = ALU_LH;
               3'b010:  dec_aluop = ALU_LW;
               3'b100:  dec_aluop = ALU_LBU;
               3'b101:  dec_aluop = ALU_LHU;
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            use1 = 1'b1; use2 = 1'b1;
            dec_reg1 = op1; dec_reg2 = op2; dec_imm = imms;
            case (funct3)
               3'b000:  dec_aluop = ALU_SB;
               3'b001:  dec_aluop = ALU_SH;
               3'b010:  dec_aluop = ALU_SW;
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_MISC_MEM: begin
            dec_aluop = ALU_NOP;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_aluop  = ALU_NOP;
         dec_reg1   = '0;
         dec_reg2   = '0;
         dec_imm    = '0;
         dec_link   = '0;
         dec_target = '0;
         dec_wd     = '0;
         dec_wreg   = 1'b0;
         dec_taken  = 1'b0;
         use1       = 1'b0;
         use2       = 1'b0;
      end
      if (dec_wd == 5'd0) dec_wreg = 1'b0;
   end

   // Handshake: wrong-path drops bypass the hazard check and backpressure
   always_comb begin
      drop       = in_valid_i && (state == ST_REDIRECT) && (pc_i != jump_addr_o);
      hazard     = in_valid_i && !drop && ((use1 && pend1) || (use2 && pend2));
      in_ready_o = drop || (!hazard && (!out_valid_o || out_ready_i));
      accept     = in_valid_i && !drop && !hazard && (!out_valid_o || out_ready_i);
   end

   // Output bundle register, redirect pulse and RUN/REDIRECT state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         out_valid_o <= 1'b0;
         aluop_o     <= '0;
         reg1_o      <= '0;
         reg2_o      <= '0;
         imm_o       <= '0;
         wd_o        <= '0;
         wreg_o      <= 1'b0;
         link_o      <= '0;
         illegal_o   <= 1'b0;
         jump_o      <= 1'b0;
         jump_addr_o <= '0;
      end else begin
         jump_o <= 1'b0;
         if (accept) begin
            out_valid_o <= 1'b1;
            aluop_o     <= ALUOP_W'(dec_aluop);
            reg1_o      <= dec_reg1;
            reg2_o      <= dec_reg2;
            imm_o       <= dec_imm;
            wd_o        <= dec_wd;
            wreg_o      <= dec_wreg;
            link_o      <= dec_link;
            illegal_o   <= dec_illegal;
            if (dec_taken) begin
               jump_o      <= 1'b1;
               jump_addr_o <= dec_target;
               state       <= ST_REDIRECT;
            end else begin
               state <= ST_RUN;
            end
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

   // Saturating count of cycles spent stalled on a pending load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (hazard && (stall_cnt_o != {SCNT_W{1'b1}})) begin
         stall_cnt_o <= stall_cnt_o + SCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: expected bundles are queued as
// instructions are presented and compared when the stage issues them.
module tb_id_decode_stage;
   import riscv_pkg::*;

   localparam int XLEN    = 32;
   localparam int NFWD    = 2;
   localparam int ALUOP_W = 6;
   localparam int SCNT_W  = 16;

   typedef struct packed {
      logic [5:0]  aluop;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        illegal;
   } bundle_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [XLEN-1:0]      pc_i;
   logic [31:0]          inst_i;
   logic [4:0]           reg1_addr_o, reg2_addr_o;
   logic [XLEN-1:0]      data1_i, data2_i;
   logic [NFWD-1:0]      fwd_wreg_i;
   logic [NFWD*5-1:0]    fwd_wd_i;
   logic [NFWD*XLEN-1:0] fwd_wdata_i;
   logic [NFWD-1:0]      fwd_pend_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [ALUOP_W-1:0]   aluop_o;
   logic [XLEN-1:0]      reg1_o, reg2_o, imm_o, link_o, jump_addr_o;
   logic [4:0]           wd_o;
   logic                 wreg_o, illegal_o, jump_o;
   logic [SCNT_W-1:0]    stall_cnt_o;

   logic [XLEN-1:0] rf [32];
   bundle_t         sb [$];
   bundle_t         got, exp_b;
   int              checks = 0;
   int              passed = 0;

   assign data1_i = rf[reg1_addr_o];
   assign data2_i = rf[reg2_addr_o];
   assign got     = {aluop_o, reg1_o, reg2_o, wd_o, wreg_o, illegal_o};

   id_decode_stage #(.XLEN(XLEN), .NFWD(NFWD), .ALUOP_W(ALUOP_W), .SCNT_W(SCNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .data1_i(data1_i), .data2_i(data2_i), .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
      .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
      .imm_o(imm_o), .wd_o(wd_o), .wreg_o(wreg_o), .link_o(link_o), .illegal_o(illegal_o),
      .jump_o(jump_o), .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      in_valid_i = v;
      pc_i       = pc;
      inst_i     = inst;
   endtask

   task automatic set_fwd(input int k, input logic w, input logic [4:0] wd,
                          input logic [31:0] data, input logic pend);
      fwd_wreg_i[k]          = w;
      fwd_wd_i[k*5 +: 5]     = wd;
      fwd_wdata_i[k*32 +: 32] = data;
      fwd_pend_i[k]          = pend;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      out_ready_i = 1'b1;
      fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_pend_i = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      @(negedge clk);
      checks++; if (out_valid_o !== 1'b0 || jump_o !== 1'b0) $display("FAIL reset_ctrl valid=%0b jump=%0b required 0/0", out_valid_o, jump_o); else passed++;
      checks++; if (got !== '0 || jump_addr_o !== '0 || link_o !== '0 || imm_o !== '0) $display("FAIL reset_bundle got=%h jaddr=%h required 0", got, jump_addr_o); else passed++;
      checks++; if (stall_cnt_o !== '0) $display("FAIL reset_stall got=%0d required 0", stall_cnt_o); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_addi();
      drive(1'b1, 32'h100, enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, 7'b0010011));
      #1;
      checks++; if (in_ready_o !== 1'b1) $display("FAIL addi_ready got=%0b required 1", in_ready_o); else passed++;
      sb.push_back('{ALU_ADD, 32'h0, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL addi_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL addi_bundle got=%h required %h", got, exp_b); else passed++; end
      @(negedge clk);
      checks++; if (out_valid_o !== 1'b0) $display("FAIL addi_drain valid=%0b required 0", out_valid_o); else passed++;
   endtask

   task automatic test_forward();
      logic [31:0] add_inst;
      add_inst = enc_r(F7_BASE, 5'd2, 5'd1, 3'b000, 5'd3);
      rf[1] = 32'h11;
      for (int n = 0; n < 3; n++) begin
         case (n)
            0: begin set_fwd(0, 1'b1, 5'd1, 32'd7, 1'b0); set_fwd(1, 1'b1, 5'd2, 32'd9, 1'b0);
                     sb.push_back('{ALU_ADD, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0}); end
            1: begin set_fwd(0, 1'b1, 5'd0, 32'd7, 1'b0);
                     sb.push_back('{ALU_ADD, 32'h11, 32'd9, 5'd3, 1'b1, 1'b0}); end
            default: begin set_fwd(0, 1'b1, 5'd1, 32'd7, 1'b0); set_fwd(1, 1'b1, 5'd1, 32'd8, 1'b0);
                     sb.push_back('{ALU_ADD, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0}); end
         endcase
         drive(1'b1, 32'h104 + 32'(n * 4), add_inst);
         #1;
         checks++; if (in_ready_o !== 1'b1) $display("FAIL fwd_ready%0d got=%0b required 1", n, in_ready_o); else passed++;
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL fwd_issue%0d valid=%0b required 1", n, out_valid_o);
         else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL fwd_bundle%0d got=%h required %h", n, got, exp_b); else passed++; end
      end
      drive(1'b0, 32'h0, 32'h0);
      set_fwd(0, 1'b0, 5'd0, 32'd0, 1'b0); set_fwd(1, 1'b0, 5'd0, 32'd0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_load_use();
      rf[4] = 32'd3;
      set_fwd(0, 1'b1, 5'd5, 32'h50, 1'b1);
      drive(1'b1, 32'h120, enc_r(F7_ALT, 5'd4, 5'd5, 3'b000, 5'd6));
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (in_ready_o !== 1'b0) $display("FAIL stall_ready%0d got=%0b required 0", c, in_ready_o); else passed++;
         @(negedge clk);
      end
      checks++; if (stall_cnt_o !== 16'd2 || out_valid_o !== 1'b0) $display("FAIL stall_count got=%0d valid=%0b required 2/0", stall_cnt_o, out_valid_o); else passed++;
      set_fwd(0, 1'b1, 5'd5, 32'h50, 1'b0);
      #1;
      checks++; if (in_ready_o !== 1'b1) $display("FAIL stall_release got=%0b required 1", in_ready_o); else passed++;
      sb.push_back('{ALU_SUB, 32'h50, 32'd3, 5'd6, 1'b1, 1'b0});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      set_fwd(0, 1'b0, 5'd0, 32'd0, 1'b0);
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL sub_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b || stall_cnt_o !== 16'd2) $display("FAIL sub_bundle got=%h cnt=%0d required %h cnt=2", got, stall_cnt_o, exp_b); else passed++; end
      @(negedge clk);
   endtask

   task automatic test_branch();
      rf[1] = 32'd3; rf[2] = 32'd3;
      drive(1'b1, 32'h200, enc_b(13'd16, 5'd2, 5'd1, F3_BEQ));
      sb.push_back('{ALU_BEQ, 32'd3, 32'd3, 5'd0, 1'b0, 1'b0});
      @(negedge clk);
      checks++; if (jump_o !== 1'b1 || jump_addr_o !== 32'h210) $display("FAIL beq_jump got=%0b/%h required 1/00000210", jump_o, jump_addr_o); else passed++;
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL beq_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL beq_bundle got=%h required %h", got, exp_b); else passed++; end
      for (int n = 0; n < 2; n++) begin
         drive(1'b1, 32'h204 + 32'(n * 4), enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011));
         #1;
         checks++; if (in_ready_o !== 1'b1) $display("FAIL drop_ready%0d got=%0b required 1", n, in_ready_o); else passed++;
         @(negedge clk);
         checks++; if (out_valid_o !== 1'b0 || jump_o !== 1'b0) $display("FAIL drop_out%0d valid=%0b jump=%0b required 0/0", n, out_valid_o, jump_o); else passed++;
      end
      for (int n = 0; n < 2; n++) begin
         drive(1'b1, 32'h210 + 32'(n * 4), enc_i(12'(5 + n), 5'd0, 3'b000, 5'd7, 7'b0010011));
         sb.push_back('{ALU_ADD, 32'd0, 32'(5 + n), 5'd7, 1'b1, 1'b0});
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL target_issue%0d valid=%0b required 1", n, out_valid_o);
         else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL target_bundle%0d got=%h required %h", n, got, exp_b); else passed++; end
      end
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_jalr_branch();
      rf[5] = 32'h1000;
      drive(1'b1, 32'h300, enc_i(12'hFFD, 5'd5, 3'b000, 5'd1, 7'b1100111));
      sb.push_back('{ALU_JALR, 32'h300, 32'd4, 5'd1, 1'b1, 1'b0});
      @(negedge clk);
      checks++; if (jump_o !== 1'b1 || jump_addr_o !== 32'h0FFC || link_o !== 32'h304) $display("FAIL jalr_jump got=%0b/%h/%h required 1/00000ffc/00000304", jump_o, jump_addr_o, link_o); else passed++;
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL jalr_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL jalr_bundle got=%h required %h", got, exp_b); else passed++; end
      rf[1] = 32'hFFFFFFFF; rf[2] = 32'd1;
      drive(1'b1, 32'h0FFC, enc_b(13'd8, 5'd2, 5'd1, F3_BGE));
      sb.push_back('{ALU_BGE, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1'b0});
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || jump_o !== 1'b0 || sb.size() == 0) $display("FAIL bge_issue valid=%0b jump=%0b required 1/0", out_valid_o, jump_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL bge_bundle got=%h required %h", got, exp_b); else passed++; end
      drive(1'b1, 32'h1000, enc_b(13'd8, 5'd2, 5'd1, F3_BGEU));
      sb.push_back('{ALU_BGEU, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1'b0});
      @(negedge clk);
      checks++; if (jump_o !== 1'b1 || jump_addr_o !== 32'h1008) $display("FAIL bgeu_jump got=%0b/%h required 1/00001008", jump_o, jump_addr_o); else passed++;
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL bgeu_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL bgeu_bundle got=%h required %h", got, exp_b); else passed++; end
      set_fwd(0, 1'b1, 5'd31, 32'd0, 1'b1);
      drive(1'b1, 32'h1008, 32'hFFFFFFFF);
      #1;
      checks++; if (in_ready_o !== 1'b1) $display("FAIL illegal_ready got=%0b required 1", in_ready_o); else passed++;
      sb.push_back('{ALU_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      set_fwd(0, 1'b0, 5'd0, 32'd0, 1'b0);
      checks++;
      if (out_valid_o !== 1'b1 || jump_o !== 1'b0 || sb.size() == 0) $display("FAIL illegal_issue valid=%0b jump=%0b required 1/0", out_valid_o, jump_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL illegal_bundle got=%h required %h", got, exp_b); else passed++; end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready_i = 1'b0;
      drive(1'b1, 32'h400, enc_i(12'd8, 5'd0, 3'b000, 5'd8, 7'b0010011));
      sb.push_back('{ALU_ADD, 32'd0, 32'd8, 5'd8, 1'b1, 1'b0});
      @(negedge clk);
      drive(1'b1, 32'h404, enc_i(12'd10, 5'd0, 3'b000, 5'd10, 7'b0010011));
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || sb.size() == 0 || got !== sb[0])
            $display("FAIL hold%0d ready=%0b valid=%0b got=%h required ready 0 valid 1 bundle held", c, in_ready_o, out_valid_o, got);
         else passed++;
         @(negedge clk);
      end
      out_ready_i = 1'b1;
      #1;
      checks++; if (in_ready_o !== 1'b1) $display("FAIL release_ready got=%0b required 1", in_ready_o); else passed++;
      if (sb.size() != 0) exp_b = sb.pop_front();
      sb.push_back('{ALU_ADD, 32'd0, 32'd10, 5'd10, 1'b1, 1'b0});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL second_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL second_bundle got=%h required %h", got, exp_b); else passed++; end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h500, enc_j(21'h40, 5'd0));
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      checks++; if (jump_o !== 1'b1 || jump_addr_o !== 32'h540 || out_valid_o !== 1'b1) $display("FAIL jal_jump got=%0b/%h valid=%0b required 1/00000540/1", jump_o, jump_addr_o, out_valid_o); else passed++;
      rst = 1'b1;
      #1;
      checks++; if (jump_o !== 1'b0 || out_valid_o !== 1'b0 || jump_addr_o !== '0) $display("FAIL midreset_ctrl jump=%0b valid=%0b jaddr=%h required 0", jump_o, out_valid_o, jump_addr_o); else passed++;
      checks++; if (got !== '0 || link_o !== '0 || stall_cnt_o !== '0) $display("FAIL midreset_bundle got=%h link=%h required 0", got, link_o); else passed++;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h600, enc_i(12'd11, 5'd0, 3'b000, 5'd11, 7'b0010011));
      sb.push_back('{ALU_ADD, 32'd0, 32'd11, 5'd11, 1'b1, 1'b0});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid_o !== 1'b1 || sb.size() == 0) $display("FAIL postreset_issue valid=%0b required 1", out_valid_o);
      else begin exp_b = sb.pop_front(); if (got !== exp_b) $display("FAIL postreset_bundle got=%h required %h", got, exp_b); else passed++; end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_forward();
      test_load_use();
      test_branch();
      test_jalr_branch();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", passed, checks);
      $fatal(1, "[TB] timeout");
   end

endmodule
